// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin arbiter sharing one serial TX packager among 2**IndexWidth requesters
// Ports: clk/rst (async active-high); req/data from requesters, ack back to winner;
// pkgCe/pkgData to the packager, pkgBusy from it; grant, active, error (sticky watchdog) status.
module serial_tx_arbiter #(
  parameter int IndexWidth   = 2,
  parameter int PackageWidth = 32,
  parameter int TimeoutWidth = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [2**IndexWidth-1:0]                 req,
  input  logic [2**IndexWidth*PackageWidth-1:0]    data,
  output logic [2**IndexWidth-1:0]                 ack,
  output logic                                     pkgCe,
  output logic [PackageWidth-1:0]                  pkgData,
  input  logic                                     pkgBusy,
  output logic [IndexWidth-1:0]                    grant,
  output logic                                     active,
  output logic                                     error
);
  localparam int Requesters = 2**IndexWidth;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t                   r_state, w_next;
  logic [Requesters-1:0]    r_ack;
  logic                     r_ce, r_error;
  logic [PackageWidth-1:0]  r_pkg_data;
  logic [IndexWidth-1:0]    r_grant, w_winner;
  logic [TimeoutWidth-1:0]  r_wd;
  logic                     w_timeout;
  // Scan from the largest offset down so the nearest requester after r_grant wins;
  // offset Requesters wraps to r_grant itself, giving the last winner lowest priority.
  always_comb begin
    w_winner = r_grant;
    for (int k = Requesters; k >= 1; k--)
      if (req[r_grant + IndexWidth'(k)]) w_winner = r_grant + IndexWidth'(k);
  end
  // Fires on the edge where the watchdog reaches all-ones, i.e. after 2**TimeoutWidth-1 idle cycles.
  assign w_timeout = r_wd == TimeoutWidth'(2**TimeoutWidth - 2);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = (|req && !pkgBusy) ? ISSUE : IDLE;
      ISSUE:     w_next = WAIT_BUSY;
      WAIT_BUSY: w_next = pkgBusy ? WAIT_DONE : (w_timeout ? IDLE : WAIT_BUSY);
      WAIT_DONE: w_next = pkgBusy ? WAIT_DONE : IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ack      <= '0;
      r_ce       <= 1'b0;
      r_pkg_data <= '0;
      r_grant    <= '1;
      r_error    <= 1'b0;
      r_wd       <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= '0;
      r_ce    <= 1'b0;
      if (r_state == IDLE && w_next == ISSUE) begin
        r_grant    <= w_winner;
        r_pkg_data <= data[w_winner*PackageWidth +: PackageWidth];
        r_ack      <= Requesters'(1) << w_winner;
        r_ce       <= 1'b1;
      end
      if (r_state == ISSUE) r_wd <= '0;
      if (r_state == WAIT_BUSY && !pkgBusy) begin
        r_wd <= r_wd + 1'b1;
        if (w_timeout) r_error <= 1'b1;
      end
    end
  end
  assign ack     = r_ack;
  assign pkgCe   = r_ce;
  assign pkgData = r_pkg_data;
  assign grant   = r_grant;
  assign active  = r_state != IDLE;
  assign error   = r_error;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: directed scoreboard bench for serial_tx_arbiter with a packager busy model
module tb_serial_tx_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] data;
  logic [3:0]   ack;
  logic         pkgCe;
  logic [31:0]  pkgData;
  logic         pkgBusy = 1'b0;
  logic [1:0]   grant;
  logic         active;
  logic         error;
  typedef struct packed {logic [1:0] g; logic [31:0] d;} exp_t;
  exp_t sbq[$];
  int   n_chk = 0, n_pass = 0, cyc = 0, ph = 0, busy_len = 4, lat = 0, last = 0;
  logic force_busy = 1'b0, never_busy = 1'b0;
  serial_tx_arbiter #(.IndexWidth(2), .PackageWidth(32), .TimeoutWidth(4)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack), .pkgCe(pkgCe),
    .pkgData(pkgData), .pkgBusy(pkgBusy), .grant(grant), .active(active), .error(error)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // Packager model: busy rises two cycles after it sees pkgCe and stays up busy_len cycles.
  always @(posedge clk) begin
    #3;
    if (rst) begin
      ph = 0;
      pkgBusy = 1'b0;
    end else if (force_busy) pkgBusy = 1'b1;
    else begin
      if (ph != 0) ph++;
      else if (pkgCe && !never_busy) ph = 1;
      if (ph == 3 + busy_len) ph = 0;
      pkgBusy = ph >= 3;
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic push(input int g);
    exp_t e;
    e.g = 2'(g);
    e.d = data[g*32 +: 32];
    sbq.push_back(e);
  endtask
  task automatic wait_ce(input int max, output int l);
    exp_t e;
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!pkgCe && l < max);
    chk("ce_seen", 64'(pkgCe), 1);
    if (pkgCe && sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("grant", 64'(grant), 64'(e.g));
      chk("pkgData", 64'(pkgData), 64'(e.d));
      chk("ack", 64'(ack), 64'(4'b0001 << e.g));
    end
  endtask
  task automatic wait_idle(input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (active && n < max);
    chk("idle_reached", 64'(active), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < 4; i++) data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    data[2*32 +: 32] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rst_active", 64'(active), 0);
    chk("rst_pkgCe", 64'(pkgCe), 0);
    chk("rst_ack", 64'(ack), 0);
    chk("rst_pkgData", 64'(pkgData), 0);
    chk("rst_grant", 64'(grant), 3);
    chk("rst_error", 64'(error), 0);
    rst = 1'b0;
    // single request, one-cycle latency, one-cycle pulse, data sampled only at grant
    @(negedge clk);
    req = 4'b0100;
    push(2);
    wait_ce(8, lat);
    chk("single_latency", 64'(lat), 1);
    req = '0;
    data[2*32 +: 32] = 32'h0;
    @(negedge clk);
    chk("single_ce_width", 64'(pkgCe), 0);
    chk("single_ack_width", 64'(ack), 0);
    chk("single_active", 64'(active), 1);
    chk("single_data_hold", 64'(pkgData), 64'h0000_0000_DEAD_BEEF);
    wait_idle(40);
    data[2*32 +: 32] = 32'hDEAD_BEEF;
    // round robin from reset with all requests held
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) push(i % 4);
    for (int i = 0; i < 5; i++) begin
      wait_ce(40, lat);
      if (i > 0) chk("rr_spacing_ge8", 64'(cyc - last >= 8), 1);
      last = cyc;
    end
    req = '0;
    wait_idle(40);
    // fairness: after grant 1, req 0011 wraps to 0, then back to 1
    req = 4'b0010;
    push(1);
    wait_ce(40, lat);
    req = 4'b0011;
    push(0);
    push(1);
    wait_ce(40, lat);
    wait_ce(40, lat);
    req = '0;
    wait_idle(40);
    // busy blocking: nothing issued while the packager is busy
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    req = 4'b0001;
    push(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("busy_no_ce", 64'(pkgCe), 0);
      chk("busy_no_ack", 64'(ack), 0);
    end
    force_busy = 1'b0;
    wait_ce(8, lat);
    chk("busy_release_latency", 64'(lat), 2);
    req = '0;
    wait_idle(40);
    // watchdog: busy never rises, error after 15 cycles in WAIT_BUSY
    never_busy = 1'b1;
    req = 4'b0100;
    push(2);
    wait_ce(8, lat);
    req = '0;
    repeat (15) @(negedge clk);
    chk("wd_still_waiting", 64'(active), 1);
    chk("wd_no_error_yet", 64'(error), 0);
    @(negedge clk);
    chk("wd_back_idle", 64'(active), 0);
    chk("wd_error_set", 64'(error), 1);
    never_busy = 1'b0;
    req = 4'b1000;
    push(3);
    wait_ce(8, lat);
    chk("wd_next_latency", 64'(lat), 1);
    req = '0;
    wait_idle(40);
    chk("wd_error_sticky", 64'(error), 1);
    // reset during WAIT_DONE takes effect without a clock edge
    req = 4'b0001;
    push(0);
    wait_ce(8, lat);
    req = '0;
    repeat (4) @(negedge clk);
    chk("mid_active_before", 64'(active), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_active", 64'(active), 0);
    chk("mid_rst_pkgCe", 64'(pkgCe), 0);
    chk("mid_rst_ack", 64'(ack), 0);
    chk("mid_rst_grant", 64'(grant), 3);
    chk("mid_rst_error", 64'(error), 0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1000;
    push(3);
    wait_ce(8, lat);
    chk("post_rst_latency", 64'(lat), 1);
    req = '0;
    wait_idle(40);
    chk("sb_drained", 64'(sbq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
